// File: rtl/uart_pkg.sv
// Line-level UART definitions shared by the transmit and receive controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam logic MARK  = 1'b1;
    localparam logic SPACE = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the terminal count and the cycle before it.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (bit_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = (count == CW'(CLKS_PER_BIT - 1));
    // Lets the controller register done so it lands on the final cycle of the frame.
    assign pre_tick = (count == CW'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, LSB-first data, optional parity, one or two stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam logic       HAS_PARITY = (PARITY_EN != 0);
    localparam logic       ODD        = (PARITY_ODD != 0);
    localparam logic       LAST_STOP  = (STOP_BITS == 2);
    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 bit_tick;
    logic                 pre_tick;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == TX_IDLE),
        .bit_tick(bit_tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= TX_IDLE;
            tx         <= MARK;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        shreg      <= tx_data;
                        parity_bit <= ^tx_data ^ ODD;
                        state      <= TX_START;
                        tx         <= SPACE;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                TX_START: begin
                    if (bit_tick) begin
                        state   <= TX_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                TX_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            if (HAS_PARITY) begin
                                state <= TX_PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state    <= TX_STOP;
                                stop_idx <= 1'b0;
                                tx       <= MARK;
                            end
                        end else begin
                            // tx is registered, so it takes the bit that becomes shreg[0] after this shift.
                            bit_idx <= bit_idx + 4'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (bit_tick) begin
                        state    <= TX_STOP;
                        stop_idx <= 1'b0;
                        tx       <= MARK;
                    end
                end
                TX_STOP: begin
                    if (pre_tick && stop_idx == LAST_STOP) begin
                        done <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (stop_idx == LAST_STOP) begin
                            state    <= TX_IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            stop_idx <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= TX_IDLE;
                    tx       <= MARK;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench: drivers queue hand-computed frames, per-instance line monitors decode tx and compare.
module tb_uart_tx_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic       tx_valid_v [4];
    logic [7:0] tx_data_v  [4];
    logic       ready_v    [4];
    logic       tx_v       [4];
    logic       busy_v     [4];
    logic       done_v     [4];

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clock(clock), .reset(reset), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
        .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clock(clock), .reset(reset), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
        .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clock(clock), .reset(reset), .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]),
        .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    uart_tx_ctrl #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clock(clock), .reset(reset), .tx_data(tx_data_v[3]), .tx_valid(tx_valid_v[3]),
        .tx_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       par;
        int         len;
        int         start_cyc;
        int         gap;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   stray_done [4];
    int   frames     [4];

    function automatic void check(input string name, input int id, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s[dut%0d]: got %0d, expected %0d", name, id, got, want);
    endfunction

    task automatic monitor(input int id, input int cpb, input int nbits, input int par_en, input int stopb);
        int          gap;
        int          start_gap;
        int          nslot;
        int          start;
        int          done_at;
        int          done_cnt;
        int          idx;
        bit          aborted;
        bit          glitch;
        bit          stop_ok;
        logic        v;
        logic [15:0] slots;
        logic [7:0]  got_d;
        exp_t        e;
        gap = 1000;
        forever begin
            @(negedge clock);
            if (!reset) begin
                gap = 1000;
                continue;
            end
            if (done_v[id]) stray_done[id]++;
            if (!(busy_v[id] && tx_v[id] == 1'b0)) begin
                gap++;
                continue;
            end
            start_gap = gap;
            nslot     = 1 + nbits + par_en + stopb;
            start     = int'(cyc);
            done_at   = 0;
            done_cnt  = 0;
            aborted   = 1'b0;
            glitch    = 1'b0;
            slots     = '0;
            for (int c = 0; c < nslot * cpb; c++) begin
                if (c > 0) @(negedge clock);
                if (!reset) begin
                    aborted = 1'b1;
                    break;
                end
                v = tx_v[id];
                if (c % cpb == 0) slots[c / cpb] = v;
                else if (v != slots[c / cpb]) glitch = 1'b1;
                if (done_v[id]) begin
                    done_cnt++;
                    done_at = c + 1;
                end
            end
            if (aborted) begin
                gap = 1000;
                continue;
            end
            @(negedge clock);
            check("idle_after_done", id, int'({ready_v[id], tx_v[id], busy_v[id], done_v[id]}), 'b1100);
            gap = 1;
            idx = -1;
            foreach (sbq[i]) if (idx < 0 && sbq[i].id == id) idx = i;
            if (idx < 0) begin
                checks++;
                $display("FAIL unexpected_frame[dut%0d]: got a frame, expected none", id);
                continue;
            end
            e = sbq[idx];
            sbq.delete(idx);
            frames[id]++;
            got_d = '0;
            for (int k = 0; k < nbits && k < 8; k++) got_d[k] = slots[1 + k];
            stop_ok = 1'b1;
            for (int s = 1 + nbits + par_en; s < nslot; s++) if (slots[s] != 1'b1) stop_ok = 1'b0;
            check("start_bit", id, int'(slots[0]), 0);
            check("data", id, int'(got_d), int'(e.data));
            if (par_en != 0) check("parity", id, int'(slots[1 + nbits]), int'(e.par));
            check("stop_bits", id, int'(stop_ok), 1);
            check("bit_stable", id, int'(glitch), 0);
            check("done_count", id, done_cnt, 1);
            check("done_cycle", id, done_at, e.len);
            check("start_latency", id, start, e.start_cyc);
            if (e.gap >= 0) check("mark_gap", id, start_gap, e.gap);
        end
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic p, input int len,
                        input int gap, input bit keep, input bit expect_frame);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clock);
        tx_data_v[id]  = d;
        tx_valid_v[id] = 1'b1;
        while (!ready_v[id] && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) begin
            checks++;
            $display("FAIL accept_timeout[dut%0d]: tx_ready stayed 0 for %0d cycles, expected 1", id, t);
            tx_valid_v[id] = 1'b0;
            return;
        end
        if (expect_frame) begin
            e = '{id, d, p, len, int'(cyc) + 1, gap};
            sbq.push_back(e);
        end
        @(posedge clock);
        #1;
        if (!keep) tx_valid_v[id] = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (sbq.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d frames outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 4; i++)
            check(tag, i, int'({tx_v[i], ready_v[i], busy_v[i], done_v[i]}), 'b1100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            tx_valid_v[i] = 1'b0;
            tx_data_v[i]  = '0;
            stray_done[i] = 0;
            frames[i]     = 0;
        end
        fork
            monitor(0, 4, 8, 0, 1);
            monitor(1, 4, 8, 1, 1);
            monitor(2, 4, 8, 1, 1);
            monitor(3, 2, 8, 0, 2);
        join_none

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        check_reset_state("reset_state");

        send(0, 8'h55, 1'b0, 40, -1, 1'b0, 1'b1);
        wait_drain();

        send(1, 8'h07, 1'b1, 44, -1, 1'b0, 1'b1);
        wait_drain();
        send(2, 8'h07, 1'b0, 44, -1, 1'b0, 1'b1);
        wait_drain();
        send(1, 8'hA5, 1'b0, 44, -1, 1'b0, 1'b1);
        wait_drain();

        // 0xFF presented with tx_valid held for the whole 0x00 frame
        send(0, 8'h00, 1'b0, 40, -1, 1'b1, 1'b1);
        send(0, 8'hFF, 1'b0, 40, 1, 1'b0, 1'b1);
        wait_drain();
        repeat (50) @(negedge clock);

        // Abort during data bit 3 (cycles 17..20 after accept)
        send(0, 8'h5A, 1'b0, 40, -1, 1'b0, 1'b0);
        repeat (17) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        check_reset_state("mid_frame_reset");
        send(0, 8'hA5, 1'b0, 40, -1, 1'b0, 1'b1);
        wait_drain();

        send(0, 8'hA5, 1'b0, 40, -1, 1'b1, 1'b1);
        send(0, 8'h3C, 1'b0, 40, 1, 1'b0, 1'b1);
        wait_drain();

        send(3, 8'h80, 1'b0, 22, -1, 1'b0, 1'b1);
        wait_drain();
        repeat (20) @(negedge clock);

        for (int i = 0; i < 4; i++) check("stray_done", i, stray_done[i], 0);
        check("frame_count", 0, frames[0], 6);
        check("frame_count", 1, frames[1], 2);
        check("frame_count", 2, frames[2], 1);
        check("frame_count", 3, frames[3], 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
